vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
Parametrised VGA timing and test-pattern generator. It is the next generation of the team's fixed 640x480 top-level pattern source and drives the board VGA connector (hs, vs, RGB) directly. Differences from the fixed version:
- timing, colour depth and pixel-clock divider are parameters;
- eight pattern modes, including an animated one;
- data-enable, pixel coordinates and frame-start outputs for downstream overlay logic.

Parameters:
CLK_DIV, 5, system clocks per pixel (125 MHz -> 25 MHz); >=1
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
COLOR_W, 4, bits per colour channel
BOX_SIZE, 32, moving-box edge length (pixels)

Ports:
clk  in  1  system clock
rst  in  1  reset
pattern_select  in  3  pattern mode
o_hs  out  1  horizontal sync
o_vs  out  1  vertical sync
o_de  out  1  active-video flag
o_r_data  out  COLOR_W  red
o_g_data  out  COLOR_W  green
o_b_data  out  COLOR_W  blue
o_pix_x  out  11  column of the pixel currently on the outputs
o_pix_y  out  10  line of the pixel currently on the outputs
o_frame_start  out  1  one-clk pulse with first pixel of a frame

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
Timing
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
- Divider cnt_div runs 0..CLK_DIV-1. Pixel enable pe = (cnt_div == CLK_DIV-1). When CLK_DIV=1, pe is held at 1.
- On each pe, h_cnt increments. On wrap H_TOTAL-1 -> 0, v_cnt increments; v_cnt wraps V_TOTAL-1 -> 0.
- hs is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vs uses the same rule on v_cnt.
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).

Pipeline and outputs
- All outputs are registered and update only on pe. Each output reflects the counter state of the previous pe, so latency is 1 pixel and all outputs stay mutually aligned.
- RGB is forced to 0 whenever de = 0.
- o_frame_start = 1 for the one clk in which the outputs show h=0, v=0.

Reset
- cnt_div, h_cnt, v_cnt, box_x and pattern latch go to 0.
- o_hs and o_vs go inactive (= ~SYNC_POL).
- o_de, RGB, o_pix_x, o_pix_y and o_frame_start go to 0.
- Reset asserted mid-frame aborts the frame immediately. The first pe after release presents h=0, v=0 with o_frame_start = 1.

Pattern latch
- pattern_select is sampled only on the pe where h_cnt=0 and v_cnt=0. Mid-frame changes never tear the image.

Patterns (MAX = all-ones, 0 = zero; x, y are pixel coordinates)
- 0, colour bars: 8 bars of width H_ACTIVE/8 (integer division). Order: white, yellow, cyan, green, magenta, red, blue, black. Any remainder columns on the right are black.
- 1, checkerboard: white if x[5]^y[5], else black.
- 2, horizontal gray: r=g=b = min(x>>5, MAX).
- 3, vertical gray: r=g=b = min(y>>5, MAX).
- 4: solid white.
- 5, moving box: white box of BOX_SIZE x BOX_SIZE at (box_x, (V_ACTIVE-BOX_SIZE)/2) on a blue background.
  - box_x increments by 1 at each frame start.
  - After H_ACTIVE-BOX_SIZE, box_x wraps to 0.
  - box_x advances in every mode, not only mode 5.
- 6: solid red.
- 7: black.

Width rules: counter widths are derived from H_TOTAL and V_TOTAL with $clog2. o_pix_x and o_pix_y are zero-extended.

Decomposition:
- Package vga_pkg holds:
  - the pattern-mode localparams (PAT_BARS=0 ... PAT_BLACK=7);
  - the 8-entry colour-bar RGB constant function scaled to COLOR_W.
- One natural sub-module, vga_timing: divider, h/v counters, sync/de/frame_start generation.
- vga_pattern_gen instantiates vga_timing and adds the pattern latch, box_x and the colour pipeline register.

Test Plan:
1. Default parameters, release rst at 10 ns:
   - o_hs period = 4000 clk;
   - o_hs low for 480 clk, beginning 1 pixel after h_cnt reaches 656;
   - o_vs low for 8000 clk;
   - o_frame_start period = 2,100,000 clk.
2. Pattern 0, line 0 samples:
   - x=0 -> (F,F,F); x=80 -> (F,F,0); x=400 -> (F,0,0); x=639 -> (0,0,0);
   - x=640..799 -> RGB 0, o_de 0.
3. Switch pattern_select 0->4 at line 100:
   - rest of the frame still shows colour bars;
   - the next frame's first pixel is (F,F,F), with o_frame_start high on that pixel.
4. Pattern 2:
   - x=31 -> 0, x=32 -> 1, x=479 -> E, x=480 -> F, x=639 -> F (saturated).
5. Pattern 5 over 3 frames:
   - box left edge at x=0, 1, 2;
   - line 224, x=box_x -> (F,F,F); x=box_x+32 -> (0,0,F).
   - Force box_x=608: next frame box_x=0.
6. Assert rst mid-line at v=200:
   - o_hs and o_vs immediately inactive (1), RGB 0, o_de 0;
   - after release, the first output pixel has o_pix_x=0, o_pix_y=0 and o_frame_start=1.
   - Repeat with CLK_DIV=1: o_hs period = 800 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared pattern-mode codes and colour-bar lookup for the VGA pattern generator.
package vga_pkg;

   localparam logic [2:0] PAT_BARS    = 3'd0;
   localparam logic [2:0] PAT_CHECKER = 3'd1;
   localparam logic [2:0] PAT_HGRAY   = 3'd2;
   localparam logic [2:0] PAT_VGRAY   = 3'd3;
   localparam logic [2:0] PAT_WHITE   = 3'd4;
   localparam logic [2:0] PAT_BOX     = 3'd5;
   localparam logic [2:0] PAT_RED     = 3'd6;
   localparam logic [2:0] PAT_BLACK   = 3'd7;

   // Per-channel on/off {r,g,b}; the caller replicates each bit to COLOR_W.
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      logic [2:0] rgb;
      case (idx)
         3'd0:    rgb = 3'b111;
         3'd1:    rgb = 3'b110;
         3'd2:    rgb = 3'b011;
         3'd3:    rgb = 3'b010;
         3'd4:    rgb = 3'b101;
         3'd5:    rgb = 3'b100;
         3'd6:    rgb = 3'b001;
         default: rgb = 3'b000;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider, horizontal/vertical counters and combinational sync/de flags.
module vga_timing #(
   parameter int CLK_DIV  = 5,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW      = $clog2(H_TOTAL),
   localparam int VW      = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          pe,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          hs,
   output logic          vs,
   output logic          de,
   output logic          first,
   output logic          last
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] cnt_div;

   assign pe = (CLK_DIV == 1) ? 1'b1 : (cnt_div == DW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     cnt_div <= '0;
      else if (pe) cnt_div <= '0;
      else         cnt_div <= cnt_div + DW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pe) begin
         if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end
      end
   end

   // 32-bit compares so a sync window ending exactly at a power of two cannot overflow.
   assign hs = ((32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC))
               ? SYNC_POL : ~SYNC_POL;
   assign vs = ((32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC))
               ? SYNC_POL : ~SYNC_POL;
   assign de    = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
   assign first = (h_cnt == '0) && (v_cnt == '0);
   assign last  = (32'(h_cnt) == H_TOTAL - 1) && (32'(v_cnt) == V_TOTAL - 1);

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern source with registered, mutually aligned outputs.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 5,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int COLOR_W  = 4,
   parameter int BOX_SIZE = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         pattern_select,
   output logic               o_hs,
   output logic               o_vs,
   output logic               o_de,
   output logic [COLOR_W-1:0] o_r_data,
   output logic [COLOR_W-1:0] o_g_data,
   output logic [COLOR_W-1:0] o_b_data,
   output logic [10:0]        o_pix_x,
   output logic [9:0]         o_pix_y,
   output logic               o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   localparam int BOX_Y   = (V_ACTIVE - BOX_SIZE) / 2;
   localparam logic [COLOR_W-1:0] MAX_C = '1;

   logic          pe, hs, vs, de, first, last;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;

   vga_timing #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(H_ACTIVE),
      .H_FP    (H_FP),
      .H_SYNC  (H_SYNC),
      .H_BP    (H_BP),
      .V_ACTIVE(V_ACTIVE),
      .V_FP    (V_FP),
      .V_SYNC  (V_SYNC),
      .V_BP    (V_BP),
      .SYNC_POL(SYNC_POL)
   ) u_timing (
      .clk  (clk),
      .rst  (rst),
      .pe   (pe),
      .h_cnt(h_cnt),
      .v_cnt(v_cnt),
      .hs   (hs),
      .vs   (vs),
      .de   (de),
      .first(first),
      .last (last)
   );

   logic [2:0]    pat_latch, pat_cur;
   logic [HW-1:0] box_x;

   // Bypass lets the first pixel of a frame already use the newly sampled mode.
   assign pat_cur = first ? pattern_select : pat_latch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               pat_latch <= '0;
      else if (pe && first)  pat_latch <= pattern_select;
   end

   // Stepping on the last pixel makes the new position valid from the frame's first pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         box_x <= '0;
      end else if (pe && last) begin
         box_x <= (32'(box_x) >= H_ACTIVE - BOX_SIZE) ? '0 : box_x + HW'(1);
      end
   end

   logic [31:0]        x32, y32, bar_idx, gray_h, gray_v;
   logic               in_box, use_gray;
   logic [2:0]         flags;
   logic [COLOR_W-1:0] gray, r_c, g_c, b_c;

   always_comb begin
      x32      = 32'(h_cnt);
      y32      = 32'(v_cnt);
      bar_idx  = x32 / BAR_W;
      gray_h   = x32 >> 5;
      gray_v   = y32 >> 5;
      in_box   = (x32 >= 32'(box_x)) && (x32 < 32'(box_x) + BOX_SIZE) &&
                 (y32 >= BOX_Y) && (y32 < BOX_Y + BOX_SIZE);
      flags    = 3'b000;
      use_gray = 1'b0;
      gray     = '0;
      case (pat_cur)
         PAT_BARS:    flags = (bar_idx < 8) ? bar_rgb(bar_idx[2:0]) : 3'b000;
         PAT_CHECKER: flags = {3{x32[5] ^ y32[5]}};
         PAT_HGRAY: begin
            use_gray = 1'b1;
            gray     = (gray_h > 32'(MAX_C)) ? MAX_C : gray_h[COLOR_W-1:0];
         end
         PAT_VGRAY: begin
            use_gray = 1'b1;
            gray     = (gray_v > 32'(MAX_C)) ? MAX_C : gray_v[COLOR_W-1:0];
         end
         PAT_WHITE:   flags = 3'b111;
         PAT_BOX:     flags = in_box ? 3'b111 : 3'b001;
         PAT_RED:     flags = 3'b100;
         default:     flags = 3'b000;
      endcase
      r_c = use_gray ? gray : {COLOR_W{flags[2]}};
      g_c = use_gray ? gray : {COLOR_W{flags[1]}};
      b_c = use_gray ? gray : {COLOR_W{flags[0]}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_hs          <= ~SYNC_POL;
         o_vs          <= ~SYNC_POL;
         o_de          <= 1'b0;
         o_r_data      <= '0;
         o_g_data      <= '0;
         o_b_data      <= '0;
         o_pix_x       <= '0;
         o_pix_y       <= '0;
         o_frame_start <= 1'b0;
      end else begin
         o_frame_start <= pe && first;
         if (pe) begin
            o_hs     <= hs;
            o_vs     <= vs;
            o_de     <= de;
            o_r_data <= de ? r_c : '0;
            o_g_data <= de ? g_c : '0;
            o_b_data <= de ? b_c : '0;
            o_pix_x  <= 11'(h_cnt);
            o_pix_y  <= 10'(v_cnt);
         end
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench: two small-geometry instances (divided and undivided pixel clock).
module tb_vga_pattern_gen;

   localparam int D0 = 2, HA0 = 160, HF0 = 4, HS0 = 8, HB0 = 4, HT0 = 176;
   localparam int VA0 = 20, VF0 = 1, VS0 = 2, VB0 = 2, VT0 = 25, FT0 = HT0 * VT0;
   localparam int D1 = 1, HA1 = 20, HF1 = 2, HS1 = 3, HB1 = 3, HT1 = 28;
   localparam int VA1 = 10, VF1 = 1, VS1 = 1, VB1 = 2, VT1 = 14, FT1 = HT1 * VT1;

   localparam logic [11:0] W0 = 12'h333, Y0 = 12'h330, R0 = 12'h300, B0 = 12'h003;
   localparam logic [11:0] W1 = 12'hFFF, Y1 = 12'hFF0, B1 = 12'h00F, C1 = 12'h0FF;

   typedef struct {
      int          n;
      int          x;
      int          y;
      logic [11:0] rgb;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  pattern_select = 3'd0;
   logic [2:0]  pat1 = 3'd5;
   logic        hs0, vs0, de0, fs0, hs1, vs1, de1, fs1;
   logic [1:0]  r0, g0, b0;
   logic [3:0]  r1, g1, b1;
   logic [10:0] px0, px1;
   logic [9:0]  py0, py1;

   int unsigned pc;
   int          mon_n0 = -1, mon_n1 = -1;
   int          n_asrt = 0, n_fail = 0;
   exp_t        q0[$], q1[$];

   always #5 clk = ~clk;

   vga_pattern_gen #(
      .CLK_DIV(D0), .H_ACTIVE(HA0), .H_FP(HF0), .H_SYNC(HS0), .H_BP(HB0),
      .V_ACTIVE(VA0), .V_FP(VF0), .V_SYNC(VS0), .V_BP(VB0),
      .SYNC_POL(1'b0), .COLOR_W(2), .BOX_SIZE(8)
   ) dut (
      .clk(clk), .rst(rst), .pattern_select(pattern_select),
      .o_hs(hs0), .o_vs(vs0), .o_de(de0),
      .o_r_data(r0), .o_g_data(g0), .o_b_data(b0),
      .o_pix_x(px0), .o_pix_y(py0), .o_frame_start(fs0)
   );

   vga_pattern_gen #(
      .CLK_DIV(D1), .H_ACTIVE(HA1), .H_FP(HF1), .H_SYNC(HS1), .H_BP(HB1),
      .V_ACTIVE(VA1), .V_FP(VF1), .V_SYNC(VS1), .V_BP(VB1),
      .SYNC_POL(1'b1), .COLOR_W(4), .BOX_SIZE(4)
   ) dut1 (
      .clk(clk), .rst(rst), .pattern_select(pat1),
      .o_hs(hs1), .o_vs(vs1), .o_de(de1),
      .o_r_data(r1), .o_g_data(g1), .o_b_data(b1),
      .o_pix_x(px1), .o_pix_y(py1), .o_frame_start(fs1)
   );

   // Posedges since reset release; pixel n appears on posedge (n+1)*CLK_DIV.
   always @(posedge clk or posedge rst) begin
      if (rst) pc <= 0;
      else     pc <= pc + 1;
   end

   task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asrt++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_px(input exp_t e, input int ha, input int hss, input int hse,
                           input int va, input int vss, input int vse, input logic pol,
                           input logic hs, input logic vs, input logic de, input logic fs,
                           input logic [11:0] rgb, input logic [10:0] px, input logic [9:0] py);
      logic ede, ehs, evs;
      ede = (e.x < ha) && (e.y < va);
      ehs = (e.x >= hss && e.x < hse) ? pol : ~pol;
      evs = (e.y >= vss && e.y < vse) ? pol : ~pol;
      cmp($sformatf("%s_hs", e.tag), hs, ehs);
      cmp($sformatf("%s_vs", e.tag), vs, evs);
      cmp($sformatf("%s_de", e.tag), de, ede);
      cmp($sformatf("%s_fs", e.tag), fs, (e.x == 0 && e.y == 0));
      cmp($sformatf("%s_rgb", e.tag), rgb, e.rgb);
      if (ede) begin
         cmp($sformatf("%s_px", e.tag), px, e.x);
         cmp($sformatf("%s_py", e.tag), py, e.y);
      end
   endtask

   initial forever begin : mon0
      exp_t e;
      @(negedge clk);
      if (rst) mon_n0 = -1;
      else if (pc >= D0 && pc % D0 == 0) begin
         mon_n0 = int'(pc / D0) - 1;
         if (q0.size() > 0 && q0[0].n <= mon_n0) begin
            e = q0.pop_front();
            if (e.n != mon_n0) cmp({e.tag, "_missed"}, mon_n0, e.n);
            else check_px(e, HA0, HA0 + HF0, HA0 + HF0 + HS0, VA0, VA0 + VF0, VA0 + VF0 + VS0,
                          1'b0, hs0, vs0, de0, fs0, {2'b00, r0, 2'b00, g0, 2'b00, b0}, px0, py0);
         end
      end else if (pc > D0 && ((int'(pc / D0) - 1) % FT0) == 0) begin
         cmp("fs_one_clk", fs0, 1'b0);
      end
   end

   initial forever begin : mon1
      exp_t e;
      @(negedge clk);
      if (rst) mon_n1 = -1;
      else if (pc >= D1) begin
         mon_n1 = int'(pc) - 1;
         if (q1.size() > 0 && q1[0].n <= mon_n1) begin
            e = q1.pop_front();
            if (e.n != mon_n1) cmp({e.tag, "_missed"}, mon_n1, e.n);
            else check_px(e, HA1, HA1 + HF1, HA1 + HF1 + HS1, VA1, VA1 + VF1, VA1 + VF1 + VS1,
                          1'b1, hs1, vs1, de1, fs1, {r1, g1, b1}, px1, py1);
         end
      end
   end

   task automatic push0(input string tag, input int f, input int x, input int y, input logic [11:0] rgb);
      exp_t e;
      e.n = f * FT0 + y * HT0 + x; e.x = x; e.y = y; e.rgb = rgb; e.tag = tag;
      q0.push_back(e);
   endtask

   task automatic push1(input string tag, input int f, input int x, input int y, input logic [11:0] rgb);
      exp_t e;
      e.n = f * FT1 + y * HT1 + x; e.x = x; e.y = y; e.rgb = rgb; e.tag = tag;
      q1.push_back(e);
   endtask

   task automatic wait_q0(input string tag);
      int k = 0;
      while (q0.size() > 0 && k < 30000) begin @(negedge clk); k++; end
      if (q0.size() > 0) begin
         cmp({tag, "_timeout"}, q0.size(), 0);
         q0.delete();
      end
   endtask

   task automatic wait_q1(input string tag);
      int k = 0;
      while (q1.size() > 0 && k < 30000) begin @(negedge clk); k++; end
      if (q1.size() > 0) begin
         cmp({tag, "_timeout"}, q1.size(), 0);
         q1.delete();
      end
   endtask

   task automatic wait_n0(input string tag, input int target);
      int k = 0;
      while (mon_n0 < target && k < 30000) begin @(negedge clk); k++; end
      if (mon_n0 < target) cmp({tag, "_timeout"}, mon_n0, target);
   endtask

   task automatic check_reset(input string tag);
      cmp({tag, "_hs0"}, hs0, 1'b1);
      cmp({tag, "_vs0"}, vs0, 1'b1);
      cmp({tag, "_de0"}, de0, 1'b0);
      cmp({tag, "_rgb0"}, {r0, g0, b0}, 0);
      cmp({tag, "_pix0"}, {px0, py0}, 0);
      cmp({tag, "_fs0"}, fs0, 1'b0);
      cmp({tag, "_hs1"}, hs1, 1'b0);
      cmp({tag, "_vs1"}, vs1, 1'b0);
      cmp({tag, "_de1"}, de1, 1'b0);
      cmp({tag, "_rgb1"}, {r1, g1, b1}, 0);
      cmp({tag, "_pix1"}, {px1, py1}, 0);
      cmp({tag, "_fs1"}, fs1, 1'b0);
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int f1;
      #1 rst = 1'b1;
      #2 check_reset("reset");
      #7 rst = 1'b0;

      // Undivided instance: sync polarity, moving box over 19 frames including the wrap.
      push1("hs1_pre", 0, 21, 0, 12'h000);
      push1("hs1_on", 0, 22, 0, 12'h000);
      push1("hs1_end", 0, 24, 0, 12'h000);
      push1("hs1_post", 0, 25, 0, 12'h000);
      for (int f = 0; f < 19; f++) begin
         int bx;
         bx = f % 17;
         push1($sformatf("box1_f%0d_tl", f), f, bx, 3, W1);
         if (bx > 0)      push1($sformatf("box1_f%0d_left", f), f, bx - 1, 4, B1);
         if (bx + 4 < 20) push1($sformatf("box1_f%0d_right", f), f, bx + 4, 5, B1);
         push1($sformatf("box1_f%0d_br", f), f, bx + 3, 6, W1);
         push1($sformatf("box1_f%0d_below", f), f, bx, 7, B1);
         if (f == 0) begin
            push1("vs1_pre", 0, 0, 10, 12'h000);
            push1("vs1_on", 0, 0, 11, 12'h000);
            push1("vs1_post", 0, 0, 12, 12'h000);
         end
      end

      push0("bars_x0", 0, 0, 0, W0);
      push0("bars_x1", 0, 1, 0, W0);
      push0("bars_x19", 0, 19, 0, W0);
      push0("bars_x20", 0, 20, 0, Y0);
      push0("bars_x100", 0, 100, 0, R0);
      push0("bars_x139", 0, 139, 0, B0);
      push0("bars_x140", 0, 140, 0, 12'h000);
      push0("bars_x159", 0, 159, 0, 12'h000);
      push0("blank_x160", 0, 160, 0, 12'h000);
      push0("hs_pre", 0, 163, 0, 12'h000);
      push0("hs_on", 0, 164, 0, 12'h000);
      push0("hs_end", 0, 171, 0, 12'h000);
      push0("hs_post", 0, 172, 0, 12'h000);
      push0("hs_last", 0, 175, 0, 12'h000);
      wait_q0("stage_bars");

      wait_n0("switch", 10 * HT0 + 5);
      pattern_select = 3'd4;
      push0("no_tear_y12", 0, 20, 12, Y0);
      push0("no_tear_y19", 0, 130, 19, B0);
      push0("vs_pre", 0, 0, 20, 12'h000);
      push0("vs_on", 0, 0, 21, 12'h000);
      push0("vs_end", 0, 0, 22, 12'h000);
      push0("vs_post", 0, 0, 23, 12'h000);
      push0("white_first", 1, 0, 0, W0);
      push0("white_mid", 1, 40, 3, W0);
      wait_q0("stage_switch");

      wait_q1("stage_box1");
      pat1 = 3'd0;
      f1 = mon_n1 / FT1 + 2;
      push1("bars1_x0", f1, 0, 0, W1);
      push1("bars1_x2", f1, 2, 0, Y1);
      push1("bars1_x13", f1, 13, 0, B1);
      push1("bars1_x15", f1, 15, 0, 12'h000);
      push1("bars1_rem16", f1, 16, 0, 12'h000);
      push1("bars1_rem19", f1, 19, 0, 12'h000);

      pattern_select = 3'd2;
      push0("hgray_x0", 2, 0, 5, 12'h000);
      push0("hgray_x31", 2, 31, 5, 12'h000);
      push0("hgray_x32", 2, 32, 5, 12'h111);
      push0("hgray_x95", 2, 95, 5, 12'h222);
      push0("hgray_x96", 2, 96, 5, 12'h333);
      push0("hgray_x128", 2, 128, 5, 12'h333);
      push0("hgray_x159", 2, 159, 5, 12'h333);
      push0("hgray_blank", 2, 160, 5, 12'h000);
      wait_q0("stage_hgray");

      pattern_select = 3'd1;
      push0("chk_x31", 3, 31, 2, 12'h000);
      push0("chk_x32", 3, 32, 2, W0);
      push0("chk_x64", 3, 64, 2, 12'h000);
      push0("chk_x96", 3, 96, 2, W0);
      push0("chk_x159", 3, 159, 2, 12'h000);
      wait_q0("stage_checker");

      pattern_select = 3'd5;
      push0("box_above", 4, 4, 5, B0);
      push0("box_left", 4, 3, 6, B0);
      push0("box_tl", 4, 4, 6, W0);
      push0("box_br", 4, 11, 13, W0);
      push0("box_right", 4, 12, 13, B0);
      push0("box_below", 4, 4, 14, B0);
      push0("box_bg", 4, 159, 19, B0);
      push0("box_blank", 4, 160, 19, 12'h000);
      wait_q0("stage_box");

      pattern_select = 3'd6;
      push0("red_first", 5, 0, 0, R0);
      push0("red_mid", 5, 60, 10, R0);
      wait_q0("stage_red");
      wait_q1("stage_bars1");

      wait_n0("mid_frame", 5 * FT0 + 15 * HT0 + 60);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset("mid_reset");
      q0.delete();
      q1.delete();
      #25;
      @(negedge clk);
      rst = 1'b0;
      push0("post_rst_first", 0, 0, 0, R0);
      push0("post_rst_x1", 0, 1, 0, R0);
      push1("post_rst1_first", 0, 0, 0, W1);
      push1("post_rst1_cyan", 0, 5, 2, C1);
      wait_q0("stage_post");
      wait_q1("stage_post1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
